// File: rtl/dcache_pkg.sv
// Shared types and constants for the set-associative data cache.
package dcache_pkg;

  // Controller states: serve hits, flush a dirty victim, fetch the missing line.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } dcache_state_t;

  // AddrMode encoding.
  localparam logic ADDR_MODE_WORD = 1'b0;
  localparam logic ADDR_MODE_BYTE = 1'b1;

  localparam int unsigned WORD_BITS  = 32;
  localparam int unsigned BYTE_BITS  = 8;
  localparam int unsigned WORD_BYTES = WORD_BITS / BYTE_BITS;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: victim lookup and most-recently-used update for one set.
// Node n has children 2n+1 (left) and 2n+2 (right); a node bit of 0 means the
// left subtree holds the victim, and an access flips the path to point away.
module plru_tree #(
  parameter  int unsigned WAYS   = 2,
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1
) (
  input  logic [PLRU_W-1:0] tree,
  input  logic [WAY_W-1:0]  access_way,
  output logic [WAY_W-1:0]  victim,
  output logic [PLRU_W-1:0] tree_next
);

  localparam int unsigned LEVELS = $clog2(WAYS);

  // Walk the tree once to find the victim and once to mark the accessed way.
  always_comb begin
    int   node;
    logic bit_v;
    logic dir;
    victim    = '0;
    tree_next = tree;
    node      = 0;
    bit_v     = 1'b0;
    dir       = 1'b0;
    for (int l = 0; l < int'(LEVELS); l++) begin
      bit_v = 1'b0;
      for (int n = 0; n < int'(PLRU_W); n++) begin
        if (n == node) bit_v = tree[n];
      end
      victim[int'(LEVELS) - 1 - l] = bit_v;
      node = 2 * node + 1 + int'(bit_v);
    end
    node = 0;
    for (int l = 0; l < int'(LEVELS); l++) begin
      dir = access_way[int'(LEVELS) - 1 - l];
      for (int n = 0; n < int'(PLRU_W); n++) begin
        if (n == node) tree_next[n] = ~dir;
      end
      node = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/assoc_dcache.sv
// Write-back, write-allocate set-associative data cache with tree-PLRU
// replacement and a single line-wide backing-memory port.
module assoc_dcache
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        data_address,
  input  logic [WORD_BITS-1:0]         write_data,
  input  logic                         MemWrite,
  input  logic                         MemRead,
  input  logic                         AddrMode,
  output logic [WORD_BITS-1:0]         read_data,
  output logic                         stall,
  output logic                         mem_req,
  output logic                         WriteEnable,
  output logic [ADDR_WIDTH-1:0]        memory_address,
  output logic [WORD_BITS*LINE_WORDS-1:0] mem_writedata,
  input  logic [WORD_BITS*LINE_WORDS-1:0] mem_readdata,
  input  logic                         mem_ready
);

  localparam int unsigned LINE_BITS = WORD_BITS * LINE_WORDS;
  localparam int unsigned OFF_W     = $clog2(LINE_WORDS * WORD_BYTES);
  localparam int unsigned IDX_W     = $clog2(SETS);
  localparam int unsigned TAG_W     = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int unsigned BYTE_W    = $clog2(WORD_BYTES);
  localparam int unsigned WSEL_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned PLRU_W    = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int unsigned POS_W     = $clog2(LINE_BITS);

  dcache_state_t state_q;

  logic [LINE_BITS-1:0] data_q  [WAYS][SETS];
  logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
  logic                 valid_q [WAYS][SETS];
  logic                 dirty_q [WAYS][SETS];
  logic [PLRU_W-1:0]    plru_q  [SETS];
  logic [WAY_W-1:0]     victim_q;

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WSEL_W-1:0]     req_word;
  logic [BYTE_W-1:0]     req_byte;
  logic [ADDR_WIDTH-1:0] req_base;
  logic                  is_req;
  logic                  in_idle;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      fill_way;
  logic [WAY_W-1:0]      plru_victim;
  logic [WAY_W-1:0]      plru_access;
  logic [PLRU_W-1:0]     plru_next;
  logic [LINE_BITS-1:0]  line_rd;
  logic [LINE_BITS-1:0]  line_wr;
  logic [POS_W-1:0]      word_pos;
  logic [POS_W-1:0]      byte_pos;
  logic                  write_hit;
  logic                  refill_done;

  assign req_tag  = data_address[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx  = data_address[OFF_W +: IDX_W];
  assign req_word = WSEL_W'(OFF_W'(data_address) >> BYTE_W);
  assign req_byte = data_address[BYTE_W-1:0];
  assign req_base = {req_tag, req_idx, OFF_W'(0)};
  assign is_req   = MemRead | MemWrite;
  assign in_idle  = (state_q == ST_IDLE);

  assign plru_access = (state_q == ST_REFILL) ? victim_q : hit_way;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .tree       (plru_q[req_idx]),
    .access_way (plru_access),
    .victim     (plru_victim),
    .tree_next  (plru_next)
  );

  // Tag match across ways, and fill-way choice: first invalid way, else PLRU.
  always_comb begin
    logic inv_found;
    hit       = 1'b0;
    hit_way   = '0;
    fill_way  = plru_victim;
    inv_found = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[w][req_idx]) begin
        fill_way  = WAY_W'(w);
        inv_found = 1'b1;
      end
    end
  end

  // Hit-path data: load result and store-merged line.
  always_comb begin
    line_rd  = data_q[hit_way][req_idx];
    word_pos = POS_W'(req_word) << $clog2(WORD_BITS);
    byte_pos = word_pos + (POS_W'(req_byte) << $clog2(BYTE_BITS));
    line_wr  = line_rd;
    if (AddrMode == ADDR_MODE_BYTE) line_wr[byte_pos +: BYTE_BITS] = write_data[BYTE_BITS-1:0];
    else                            line_wr[word_pos +: WORD_BITS] = write_data;
    read_data = '0;
    if (in_idle && MemRead && !MemWrite && hit) begin
      if (AddrMode == ADDR_MODE_WORD) read_data = line_rd[word_pos +: WORD_BITS];
      else                            read_data = WORD_BITS'(line_rd[byte_pos +: BYTE_BITS]);
    end
    stall = in_idle ? (is_req && !hit) : 1'b1;
  end

  assign write_hit   = in_idle && MemWrite && hit;
  assign refill_done = (state_q == ST_REFILL) && mem_ready;

  // Controller: line metadata, PLRU state and the memory-port registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      mem_req        <= 1'b0;
      WriteEnable    <= 1'b0;
      memory_address <= '0;
      victim_q       <= '0;
      for (int w = 0; w < int'(WAYS); w++) begin
        for (int s = 0; s < int'(SETS); s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
      for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_req && hit) begin
            plru_q[req_idx] <= plru_next;
            if (MemWrite) dirty_q[hit_way][req_idx] <= 1'b1;
          end else if (is_req) begin
            victim_q <= fill_way;
            mem_req  <= 1'b1;
            if (valid_q[fill_way][req_idx] && dirty_q[fill_way][req_idx]) begin
              state_q        <= ST_WRITEBACK;
              WriteEnable    <= 1'b1;
              memory_address <= {tag_q[fill_way][req_idx], req_idx, OFF_W'(0)};
              mem_writedata  <= data_q[fill_way][req_idx];
            end else begin
              state_q        <= ST_REFILL;
              WriteEnable    <= 1'b0;
              memory_address <= req_base;
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ready) begin
            state_q        <= ST_REFILL;
            WriteEnable    <= 1'b0;
            memory_address <= req_base;
          end
        end
        ST_REFILL: begin
          if (mem_ready) begin
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
            plru_q[req_idx]            <= plru_next;
            state_q                    <= ST_IDLE;
            mem_req                    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Line data and tags: store hits merge in place, refills overwrite the victim.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (write_hit) begin
        data_q[hit_way][req_idx] <= line_wr;
      end else if (refill_done) begin
        data_q[victim_q][req_idx] <= mem_readdata;
        tag_q[victim_q][req_idx]  <= req_tag;
      end
    end
  end

endmodule
